// File: rtl/npu_result_drain.sv
// npu_result_drain: requantizes a captured result matrix to u8 and streams it row by row.
module npu_result_drain #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mm_done_i,
    input  logic [ACC_W-1:0]      c_in_i [ROWS][COLS],
    input  logic [3:0]            shift_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [COLS*OUT_W-1:0] out_data_o,
    output logic [1:0]            out_row_o,
    output logic                  out_last_o,
    output logic                  overrun_o
);
    localparam logic [ACC_W:0] QMAX = (ACC_W+1)'((1 << OUT_W) - 1);
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state_q, state_d;
    logic [1:0] row_q, row_d;
    logic done_q, overrun_q, overrun_d, rise, accept, cap;
    logic [COLS*OUT_W-1:0] buf_q [ROWS];
    logic [COLS*OUT_W-1:0] q_row [ROWS];
    logic [ACC_W:0] rnd, r;

    // One extra bit of headroom keeps the rounding add from wrapping before saturation.
    always_comb begin
        rnd = (shift_i != 4'd0) ? (ACC_W+1)'(1) << (shift_i - 4'd1) : '0;
        r = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                r = ({1'b0, c_in_i[i][j]} + rnd) >> shift_i;
                q_row[i][j*OUT_W +: OUT_W] = (r > QMAX) ? '1 : r[OUT_W-1:0];
            end
    end

    always_comb begin
        rise = mm_done_i & ~done_q;
        accept = out_valid_o & out_ready_i;
        state_d = state_q;
        row_d = row_q;
        overrun_d = overrun_q;
        cap = 1'b0;
        if (state_q == IDLE) begin
            cap = rise;
            state_d = rise ? DRAIN : IDLE;
            row_d = '0;
        end else if (accept && row_q == LAST_ROW) begin
            cap = rise;
            state_d = rise ? DRAIN : IDLE;
            row_d = '0;
        end else begin
            row_d = accept ? row_q + 2'd1 : row_q;
            overrun_d = overrun_q | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q <= '0;
            done_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            done_q <= mm_done_i;
            overrun_q <= overrun_d;
            if (cap) for (int i = 0; i < ROWS; i++) buf_q[i] <= q_row[i];
        end
    end

    assign out_valid_o = state_q == DRAIN;
    assign in_ready_o = state_q == IDLE;
    assign out_data_o = buf_q[row_q];
    assign out_row_o = row_q;
    assign out_last_o = out_valid_o & (row_q == LAST_ROW);
    assign overrun_o = overrun_q;
endmodule

// File: tb/tb_npu_result_drain.sv
// tb_npu_result_drain: table vectors plus hand sequences, beats checked against a scoreboard queue.
module tb_npu_result_drain;
    logic clk = 1'b0;
    logic rst, mm_done_i, out_ready_i;
    logic [15:0] c_in_i [4][4];
    logic [3:0] shift_i;
    logic in_ready_o, out_valid_o, out_last_o, overrun_o;
    logic [31:0] out_data_o;
    logic [1:0] out_row_o;

    typedef struct packed {logic [31:0] data; logic [1:0] row; logic last;} beat_t;
    typedef struct packed {
        logic [15:0] fill;
        logic        use_ov;
        logic [63:0] ov;
        logic [3:0]  sh;
        logic [31:0] exp0;
        logic [31:0] exp_n;
    } vec_t;

    beat_t sb[$];
    beat_t mon_e;
    vec_t vt[7];
    int checks = 0, failures = 0, pushed = 0, popped = 0;

    always #5 clk = ~clk;

    npu_result_drain dut (
        .clk(clk), .rst(rst), .mm_done_i(mm_done_i), .c_in_i(c_in_i), .shift_i(shift_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_row_o(out_row_o), .out_last_o(out_last_o),
        .overrun_o(overrun_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rq(input logic [15:0] c, input logic [3:0] s);
        int si, t;
        si = int'(s);
        t = int'(c) + (si != 0 ? (1 << (si - 1)) : 0);
        t = t >> si;
        return t > 255 ? 8'hFF : t[7:0];
    endfunction

    task automatic set_c(input logic [15:0] fill, input logic use_ov, input logic [63:0] ov);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c_in_i[i][j] = (use_ov && i == 0) ? ov[16*j +: 16] : fill;
    endtask

    task automatic push(input logic [127:0] beats);
        beat_t b;
        for (int r = 0; r < 4; r++) begin
            b.data = beats[32*r +: 32];
            b.row = 2'(r);
            b.last = (r == 3);
            sb.push_back(b);
            pushed++;
        end
    endtask

    task automatic capture(input logic [3:0] sh, input logic [127:0] beats, input bit hold);
        shift_i = sh;
        mm_done_i = 1'b1;
        push(beats);
        @(posedge clk);
        #1;
        chk("in_ready_low", 32'(in_ready_o), 32'd0);
        chk("valid_after_cap", 32'(out_valid_o), 32'd1);
        shift_i = ~sh;
        set_c(16'h1234, 1'b0, 64'd0);
        if (!hold) mm_done_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid_o) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
            pushed -= sb.size();
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (out_valid_o && out_ready_i) begin
            popped++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat got data=%h row=%0d expected no beat", out_data_o, out_row_o);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_data", out_data_o, mon_e.data);
                chk("beat_row", 32'(out_row_o), 32'(mon_e.row));
                chk("beat_last", 32'(out_last_o), 32'(mon_e.last));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] beats;
        logic [3:0] s;
        vt[0] = '{16'h0010, 1'b0, 64'h0, 4'd0, 32'h10101010, 32'h10101010};
        vt[1] = '{16'h0010, 1'b0, 64'h0, 4'd4, 32'h01010101, 32'h01010101};
        vt[2] = '{16'h0010, 1'b1, 64'h0000_FFFF_0017_0018, 4'd4, 32'h00FF0102, 32'h01010101};
        vt[3] = '{16'hFFFF, 1'b0, 64'h0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[4] = '{16'hFFFF, 1'b0, 64'h0, 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[5] = '{16'hFFFF, 1'b0, 64'h0, 4'd15, 32'h02020202, 32'h02020202};
        vt[6] = '{16'h00FF, 1'b0, 64'h0, 4'd1, 32'h80808080, 32'h80808080};

        rst = 1'b1;
        mm_done_i = 1'b0;
        out_ready_i = 1'b1;
        shift_i = 4'd0;
        set_c(16'h0000, 1'b0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_row", 32'(out_row_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // mm_done stays high through each drain: only one capture may result
        for (int k = 0; k < $size(vt); k++) begin
            set_c(vt[k].fill, vt[k].use_ov, vt[k].ov);
            capture(vt[k].sh, {vt[k].exp_n, vt[k].exp_n, vt[k].exp_n, vt[k].exp0}, 1'b1);
            repeat (8) @(posedge clk);
            #1;
            wait_drain();
            chk("in_ready_after", 32'(in_ready_o), 32'd1);
            mm_done_i = 1'b0;
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    c_in_i[i][j] = 16'($urandom_range(0, 65535));
            s = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    beats[32*i + 8*j +: 8] = rq(c_in_i[i][j], s);
            capture(s, beats, 1'b0);
            wait_drain();
            @(posedge clk);
            #1;
        end

        set_c(16'h0060, 1'b0, 64'd0);
        capture(4'd1, {4{32'h30303030}}, 1'b0);
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid_o), 32'd1);
            chk("bp_row", 32'(out_row_o), 32'd1);
            chk("bp_data", out_data_o, 32'h30303030);
            @(posedge clk);
            #1;
        end
        out_ready_i = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;

        set_c(16'h0040, 1'b0, 64'd0);
        capture(4'd0, {4{32'h40404040}}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        set_c(16'h0050, 1'b0, 64'd0);
        shift_i = 4'd0;
        mm_done_i = 1'b1;
        push({4{32'h50505050}});
        @(posedge clk);
        #1;
        chk("recap_valid", 32'(out_valid_o), 32'd1);
        chk("recap_row", 32'(out_row_o), 32'd0);
        chk("recap_in_ready", 32'(in_ready_o), 32'd0);
        wait_drain();
        mm_done_i = 1'b0;
        chk("recap_overrun", 32'(overrun_o), 32'd0);
        @(posedge clk);
        #1;

        set_c(16'h0020, 1'b0, 64'd0);
        capture(4'd0, {4{32'h20202020}}, 1'b0);
        @(posedge clk);
        #1;
        set_c(16'h0030, 1'b0, 64'd0);
        shift_i = 4'd3;
        mm_done_i = 1'b1;
        @(posedge clk);
        #1;
        chk("overrun_set", 32'(overrun_o), 32'd1);
        mm_done_i = 1'b0;
        wait_drain();
        chk("overrun_sticky", 32'(overrun_o), 32'd1);
        chk("overrun_idle", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;

        set_c(16'h0070, 1'b0, 64'd0);
        capture(4'd0, {4{32'h70707070}}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_row", 32'(out_row_o), 32'd2);
        out_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushed -= sb.size();
        sb.delete();
        chk("mrst_valid", 32'(out_valid_o), 32'd0);
        chk("mrst_last", 32'(out_last_o), 32'd0);
        chk("mrst_row", 32'(out_row_o), 32'd0);
        chk("mrst_data", out_data_o, 32'd0);
        chk("mrst_in_ready", 32'(in_ready_o), 32'd1);
        chk("mrst_overrun", 32'(overrun_o), 32'd0);
        out_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mrst_quiet", 32'(out_valid_o), 32'd0);

        chk("beat_count", 32'(popped), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
